// File: rtl/fifo_async_pkg.sv
// Shared pointer width defaults and Gray/binary conversions for the async FIFO pointer logic.
// Conversions run on a wide zero-extended code so any pointer width up to CODE_W can use them.
package fifo_async_pkg;

   localparam int unsigned FIFO_ADDRSIZE = 4;
   localparam int unsigned FIFO_PTRW     = FIFO_ADDRSIZE + 1;
   localparam int unsigned CODE_W        = 32;

   // Leading zeros stay zero in both directions, so zero-extension keeps results exact.
   function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
      logic [CODE_W-1:0] b;
      b[CODE_W-1] = g[CODE_W-1];
      for (int i = CODE_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module sync_2ff #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/rptr_empty_wdom.sv
// Read pointer, empty / almost-empty flags, fill count and sticky underflow for the
// return-path async FIFO whose consumer runs on wclk.
module rptr_empty_wdom
   import fifo_async_pkg::*;
#(
   parameter int unsigned ADDRSIZE      = FIFO_ADDRSIZE,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                rinc,
   input  logic [ADDRSIZE:0]   wptr_a,
   output logic [ADDRSIZE:0]   rptr,
   output logic [ADDRSIZE-1:0] raddr,
   output logic                rempty,
   output logic                raempty,
   output logic [ADDRSIZE:0]   rcount,
   output logic                rerr
);

   localparam int unsigned PTRW = ADDRSIZE + 1;

   logic [PTRW-1:0] w_rwptr2;
   logic [PTRW-1:0] w_rbin;
   logic [PTRW-1:0] w_rbnext;
   logic [PTRW-1:0] w_rgnext;
   logic [PTRW-1:0] w_wbin;
   logic [PTRW-1:0] w_rcount_next;
   logic            w_pop;
   logic            r_raddr_msb;

   sync_2ff #(
      .W (PTRW)
   ) u_wptr_sync (
      .clk   (wclk),
      .rst_n (wrst_n),
      .i_d   (wptr_a),
      .o_q   (w_rwptr2)
   );

   // Next pointer; a request against an empty FIFO leaves the pointer where it is.
   always_comb begin
      w_pop         = rinc & ~rempty;
      w_rbin        = PTRW'(gray2bin(CODE_W'(rptr)));
      w_rbnext      = w_rbin + PTRW'(w_pop);
      w_rgnext      = PTRW'(bin2gray(CODE_W'(w_rbnext)));
      w_wbin        = PTRW'(gray2bin(CODE_W'(w_rwptr2)));
      w_rcount_next = w_wbin - w_rbnext;
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         rptr        <= '0;
         r_raddr_msb <= 1'b0;
         rempty      <= 1'b1;
         raempty     <= 1'b1;
         rcount      <= '0;
         rerr        <= 1'b0;
      end else begin
         rptr        <= w_rgnext;
         r_raddr_msb <= w_rgnext[ADDRSIZE] ^ w_rgnext[ADDRSIZE-1];
         rempty      <= (w_rgnext == w_rwptr2);
         raempty     <= (w_rcount_next <= PTRW'(AEMPTY_THRESH));
         rcount      <= w_rcount_next;
         rerr        <= rerr | (rinc & rempty);
      end
   end

   // Upper address bit is binary; the rest are taken straight from the Gray pointer.
   assign raddr = {r_raddr_msb, rptr[ADDRSIZE-2:0]};

endmodule

// File: tb/tb_rptr_empty_wdom.sv
// Directed bench for rptr_empty_wdom at ADDRSIZE=4, AEMPTY_THRESH=2.
module tb_rptr_empty_wdom;

   logic       wclk;
   logic       wrst_n;
   logic       rinc;
   logic [4:0] wptr_a;
   logic [4:0] rptr;
   logic [3:0] raddr;
   logic       rempty;
   logic       raempty;
   logic [4:0] rcount;
   logic       rerr;

   int n_checks;
   int n_fail;

   rptr_empty_wdom #(
      .ADDRSIZE      (4),
      .AEMPTY_THRESH (2)
   ) dut (
      .wclk    (wclk),
      .wrst_n  (wrst_n),
      .rinc    (rinc),
      .wptr_a  (wptr_a),
      .rptr    (rptr),
      .raddr   (raddr),
      .rempty  (rempty),
      .raempty (raempty),
      .rcount  (rcount),
      .rerr    (rerr)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   function automatic logic [4:0] gray5(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   // Memory address: binary bit 3 on top, Gray bits 2:0 below.
   function automatic logic [3:0] addr_of(input logic [4:0] b);
      logic [4:0] g;
      g = b ^ (b >> 1);
      return {b[3], g[2:0]};
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge wclk);
         #1;
      end
   endtask

   task automatic check_idle(input string tag);
      n_checks++;
      if (rempty !== 1'b1) begin
         $display("FAIL %s_rempty: got %b want 1", tag, rempty); n_fail++;
      end
      n_checks++;
      if (raempty !== 1'b1) begin
         $display("FAIL %s_raempty: got %b want 1", tag, raempty); n_fail++;
      end
      n_checks++;
      if (rcount !== 5'd0) begin
         $display("FAIL %s_rcount: got %0d want 0", tag, rcount); n_fail++;
      end
      n_checks++;
      if (rptr !== 5'd0) begin
         $display("FAIL %s_rptr: got %b want 00000", tag, rptr); n_fail++;
      end
      n_checks++;
      if (raddr !== 4'd0) begin
         $display("FAIL %s_raddr: got %0d want 0", tag, raddr); n_fail++;
      end
      n_checks++;
      if (rerr !== 1'b0) begin
         $display("FAIL %s_rerr: got %b want 0", tag, rerr); n_fail++;
      end
   endtask

   task automatic do_reset();
      wrst_n = 1'b0;
      rinc   = 1'b0;
      wptr_a = 5'd0;
      step(2);
      wrst_n = 1'b1;
      step(1);
   endtask

   task automatic test_reset();
      wrst_n = 1'b0;
      rinc   = 1'b0;
      wptr_a = 5'd0;
      #3;
      for (int i = 0; i < 4; i++) begin
         wptr_a = gray5(5'(i + 1));
         step(1);
      end
      check_idle("reset");
      wptr_a = 5'd0;
      step(1);
      wrst_n = 1'b1;
      step(3);
      check_idle("post_release");
   endtask

   task automatic test_fill_drain();
      logic [4:0] exp_g [3];
      exp_g = '{5'b00001, 5'b00011, 5'b00010};
      wptr_a = 5'b00001; step(1);
      wptr_a = 5'b00011; step(1);
      wptr_a = 5'b00010; step(3);
      n_checks++;
      if (rcount !== 5'd3) begin
         $display("FAIL fill_rcount: got %0d want 3", rcount); n_fail++;
      end
      n_checks++;
      if (rempty !== 1'b0) begin
         $display("FAIL fill_rempty: got %b want 0", rempty); n_fail++;
      end
      n_checks++;
      if (raempty !== 1'b0) begin
         $display("FAIL fill_raempty: got %b want 0", raempty); n_fail++;
      end
      rinc = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1);
         n_checks++;
         if (rptr !== exp_g[k]) begin
            $display("FAIL drain_rptr[%0d]: got %b want %b", k, rptr, exp_g[k]); n_fail++;
         end
         n_checks++;
         if (rcount !== 5'(2 - k)) begin
            $display("FAIL drain_rcount[%0d]: got %0d want %0d", k, rcount, 2 - k); n_fail++;
         end
         n_checks++;
         if (rempty !== (k == 2)) begin
            $display("FAIL drain_rempty[%0d]: got %b want %b", k, rempty, (k == 2)); n_fail++;
         end
         n_checks++;
         if (raempty !== 1'b1) begin
            $display("FAIL drain_raempty[%0d]: got %b want 1", k, raempty); n_fail++;
         end
      end
      rinc = 1'b0;
      n_checks++;
      if (raddr !== 4'd2) begin
         $display("FAIL drain_raddr: got %0d want 2", raddr); n_fail++;
      end
      step(2);
      n_checks++;
      if (rerr !== 1'b0) begin
         $display("FAIL drain_rerr: got %b want 0", rerr); n_fail++;
      end
   endtask

   task automatic test_wrap();
      logic [4:0] wbin;
      logic [4:0] rb;
      do_reset();
      wbin = 5'd0;
      for (int i = 0; i < 4; i++) begin
         wbin   = wbin + 5'd1;
         wptr_a = gray5(wbin);
         step(1);
      end
      step(3);
      for (int i = 0; i < 40; i++) begin
         wbin   = wbin + 5'd1;
         wptr_a = gray5(wbin);
         rinc   = 1'b1;
         step(1);
         rb = 5'(i + 1);
         n_checks++;
         if (rptr !== gray5(rb)) begin
            $display("FAIL wrap_rptr[%0d]: got %b want %b", i, rptr, gray5(rb)); n_fail++;
         end
         n_checks++;
         if (raddr !== addr_of(rb)) begin
            $display("FAIL wrap_raddr[%0d]: got %0d want %0d", i, raddr, addr_of(rb)); n_fail++;
         end
         n_checks++;
         if (rempty !== 1'b0) begin
            $display("FAIL wrap_rempty[%0d]: got %b want 0", i, rempty); n_fail++;
         end
      end
      rinc = 1'b0;
      step(4);
      n_checks++;
      if (rcount !== 5'd4) begin
         $display("FAIL wrap_rcount: got %0d want 4", rcount); n_fail++;
      end
      n_checks++;
      if (rerr !== 1'b0) begin
         $display("FAIL wrap_rerr: got %b want 0", rerr); n_fail++;
      end
   endtask

   task automatic test_full();
      do_reset();
      wptr_a = 5'b11000;
      step(4);
      n_checks++;
      if (rcount !== 5'd16) begin
         $display("FAIL full_rcount: got %0d want 16", rcount); n_fail++;
      end
      n_checks++;
      if (raempty !== 1'b0) begin
         $display("FAIL full_raempty: got %b want 0", raempty); n_fail++;
      end
      n_checks++;
      if (rempty !== 1'b0) begin
         $display("FAIL full_rempty: got %b want 0", rempty); n_fail++;
      end
      rinc = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step(1);
         n_checks++;
         if (rcount !== 5'(16 - k)) begin
            $display("FAIL full_drain_rcount[%0d]: got %0d want %0d", k, rcount, 16 - k); n_fail++;
         end
         n_checks++;
         if (raempty !== ((16 - k) <= 2)) begin
            $display("FAIL full_drain_raempty[%0d]: got %b want %b", k, raempty, ((16 - k) <= 2)); n_fail++;
         end
         n_checks++;
         if (rempty !== (k == 16)) begin
            $display("FAIL full_drain_rempty[%0d]: got %b want %b", k, rempty, (k == 16)); n_fail++;
         end
      end
      rinc = 1'b0;
      n_checks++;
      if (rptr !== 5'b11000) begin
         $display("FAIL full_rptr: got %b want 11000", rptr); n_fail++;
      end
   endtask

   task automatic test_underflow();
      // Entered empty with rptr = Gray of 16.
      rinc = 1'b1;
      step(1);
      rinc = 1'b0;
      n_checks++;
      if (rptr !== 5'b11000) begin
         $display("FAIL uflow_rptr: got %b want 11000", rptr); n_fail++;
      end
      n_checks++;
      if (rerr !== 1'b1) begin
         $display("FAIL uflow_rerr: got %b want 1", rerr); n_fail++;
      end
      wptr_a = 5'b11001;
      step(4);
      rinc = 1'b1;
      step(1);
      rinc = 1'b0;
      n_checks++;
      if (rptr !== 5'b11001) begin
         $display("FAIL uflow_legal_rptr: got %b want 11001", rptr); n_fail++;
      end
      n_checks++;
      if (rempty !== 1'b1) begin
         $display("FAIL uflow_legal_rempty: got %b want 1", rempty); n_fail++;
      end
      step(2);
      n_checks++;
      if (rerr !== 1'b1) begin
         $display("FAIL uflow_sticky_rerr: got %b want 1", rerr); n_fail++;
      end
      wrst_n = 1'b0;
      wptr_a = 5'd0;
      #2;
      n_checks++;
      if (rerr !== 1'b0) begin
         $display("FAIL uflow_reset_rerr: got %b want 0", rerr); n_fail++;
      end
      step(1);
      wrst_n = 1'b1;
      step(1);
   endtask

   task automatic test_reset_mid_drain();
      wptr_a = gray5(5'd5);
      step(4);
      n_checks++;
      if (rcount !== 5'd5) begin
         $display("FAIL mid_pre_rcount: got %0d want 5", rcount); n_fail++;
      end
      rinc = 1'b1;
      step(1);
      n_checks++;
      if (rcount !== 5'd4) begin
         $display("FAIL mid_pop_rcount: got %0d want 4", rcount); n_fail++;
      end
      // Assert reset between edges; remote pointer still holds its old value for a while.
      wrst_n = 1'b0;
      #2;
      rinc = 1'b0;
      check_idle("mid_reset");
      step(2);
      wrst_n = 1'b1;
      wptr_a = 5'd0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         n_checks++;
         if (rempty !== 1'b1) begin
            $display("FAIL mid_release_rempty[%0d]: got %b want 1", i, rempty); n_fail++;
         end
      end
      wptr_a = 5'b00001;
      step(3);
      n_checks++;
      if (rempty !== 1'b0) begin
         $display("FAIL mid_new_rempty: got %b want 0", rempty); n_fail++;
      end
      n_checks++;
      if (rcount !== 5'd1) begin
         $display("FAIL mid_new_rcount: got %0d want 1", rcount); n_fail++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      wrst_n   = 1'b0;
      rinc     = 1'b0;
      wptr_a   = 5'd0;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_full();
      test_underflow();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
